// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared datapath types for the EX/MEM pipeline register
package ex_mem_reg_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0] regbits_t;
    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;
    typedef enum logic [1:0] {
        MEM_TO_REG_ALU  = 2'd0,
        MEM_TO_REG_DMEM = 2'd1,
        MEM_TO_REG_LINK = 2'd2,
        MEM_TO_REG_LUI  = 2'd3
    } mem_to_reg_mux_selection;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } ex_mem_state_t;
endpackage

// File: rtl/ex_mem_reg_if.sv
// ex_mem_reg_if: bundle of EX/MEM register signals, modport seen from the register
interface ex_mem_reg_if #(parameter int WORD_W = 32, parameter int REG_W = 5);
    logic              enable_EX_MEM;
    logic              flush_EX_MEM;
    logic              dREN_ID_EX;
    logic              dWEN_ID_EX;
    logic              WEN_ID_EX;
    logic              halt_ID_EX;
    logic [1:0]        mem_to_reg_ID_EX;
    logic [REG_W-1:0]  wsel_EX;
    logic [WORD_W-1:0] alu_result_EX;
    logic [WORD_W-1:0] rdat2_ID_EX;
    logic [WORD_W-1:0] next_imemaddr_ID_EX;
    logic              dhit;
    logic              dREN_EX_MEM;
    logic              dWEN_EX_MEM;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic [WORD_W-1:0] alu_result_EX_MEM;
    logic              WEN_EX_MEM;
    logic [REG_W-1:0]  wsel_EX_MEM;
    logic [1:0]        mem_to_reg_EX_MEM;
    logic [WORD_W-1:0] next_imemaddr_EX_MEM;
    logic              halt_EX_MEM;
    logic              mem_stall;
    modport ex_mem_reg (
        input  enable_EX_MEM, flush_EX_MEM, dREN_ID_EX, dWEN_ID_EX, WEN_ID_EX, halt_ID_EX,
               mem_to_reg_ID_EX, wsel_EX, alu_result_EX, rdat2_ID_EX, next_imemaddr_ID_EX, dhit,
        output dREN_EX_MEM, dWEN_EX_MEM, dmemaddr, dmemstore, alu_result_EX_MEM, WEN_EX_MEM,
               wsel_EX_MEM, mem_to_reg_EX_MEM, next_imemaddr_EX_MEM, halt_EX_MEM, mem_stall
    );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register owning the data-memory request until dhit.
// Define EX_MEM_TRACKER_EN to add cpu_tracker pass-through ports.
module ex_mem_reg import ex_mem_reg_pkg::*; #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
`ifdef EX_MEM_TRACKER_EN
    input  logic [31:0]       instruction_ID_EX,
    input  logic [31:0]       imemaddr_ID_EX,
    input  logic [5:0]        opcode_ID_EX,
    input  logic [5:0]        func_ID_EX,
    input  logic [15:0]       imm16_ID_EX,
    output logic [31:0]       instruction_EX_MEM,
    output logic [31:0]       imemaddr_EX_MEM,
    output logic [5:0]        opcode_EX_MEM,
    output logic [5:0]        func_EX_MEM,
    output logic [15:0]       imm16_EX_MEM,
`endif
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable_EX_MEM,
    input  logic              flush_EX_MEM,
    input  logic              dREN_ID_EX,
    input  logic              dWEN_ID_EX,
    input  logic              WEN_ID_EX,
    input  logic              halt_ID_EX,
    input  logic [1:0]        mem_to_reg_ID_EX,
    input  logic [REG_W-1:0]  wsel_EX,
    input  logic [WORD_W-1:0] alu_result_EX,
    input  logic [WORD_W-1:0] rdat2_ID_EX,
    input  logic [WORD_W-1:0] next_imemaddr_ID_EX,
    input  logic              dhit,
    output logic              dREN_EX_MEM,
    output logic              dWEN_EX_MEM,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] alu_result_EX_MEM,
    output logic              WEN_EX_MEM,
    output logic [REG_W-1:0]  wsel_EX_MEM,
    output logic [1:0]        mem_to_reg_EX_MEM,
    output logic [WORD_W-1:0] next_imemaddr_EX_MEM,
    output logic              halt_EX_MEM,
    output logic              mem_stall
);
    ex_mem_state_t state;
    logic          flush_pending;
    logic          ld_ren;
    logic          bubble;
    logic          load;
    // a store wins over an illegal simultaneous load request
    assign ld_ren    = dREN_ID_EX & ~dWEN_ID_EX;
    assign mem_stall = (state == REQ) & ~dhit;
    assign dmemaddr  = alu_result_EX_MEM;
    assign bubble    = (state == REQ) ? dhit & (flush_pending | flush_EX_MEM)
                                      : flush_EX_MEM | (enable_EX_MEM & halt_EX_MEM);
    assign load      = (state != REQ) & ~flush_EX_MEM & enable_EX_MEM & ~halt_EX_MEM;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state                <= IDLE;
            flush_pending        <= 1'b0;
            dREN_EX_MEM          <= 1'b0;
            dWEN_EX_MEM          <= 1'b0;
            dmemstore            <= '0;
            alu_result_EX_MEM    <= '0;
            WEN_EX_MEM           <= 1'b0;
            wsel_EX_MEM          <= '0;
            mem_to_reg_EX_MEM    <= '0;
            next_imemaddr_EX_MEM <= '0;
            halt_EX_MEM          <= 1'b0;
`ifdef EX_MEM_TRACKER_EN
            instruction_EX_MEM   <= '0;
            imemaddr_EX_MEM      <= '0;
            opcode_EX_MEM        <= '0;
            func_EX_MEM          <= '0;
            imm16_EX_MEM         <= '0;
`endif
        end else if (bubble) begin
            state             <= IDLE;
            flush_pending     <= 1'b0;
            dREN_EX_MEM       <= 1'b0;
            dWEN_EX_MEM       <= 1'b0;
            WEN_EX_MEM        <= 1'b0;
            mem_to_reg_EX_MEM <= '0;
`ifdef EX_MEM_TRACKER_EN
            instruction_EX_MEM <= '0;
`endif
        end else if (state == REQ) begin
            // the access always completes; a flush only takes effect at dhit
            flush_pending <= flush_pending | flush_EX_MEM;
            if (dhit) begin
                state       <= DONE;
                dREN_EX_MEM <= 1'b0;
                dWEN_EX_MEM <= 1'b0;
            end
        end else if (load) begin
            state                <= (ld_ren | dWEN_ID_EX) ? REQ : IDLE;
            dREN_EX_MEM          <= ld_ren;
            dWEN_EX_MEM          <= dWEN_ID_EX;
            dmemstore            <= rdat2_ID_EX;
            alu_result_EX_MEM    <= alu_result_EX;
            WEN_EX_MEM           <= WEN_ID_EX;
            wsel_EX_MEM          <= wsel_EX;
            mem_to_reg_EX_MEM    <= mem_to_reg_ID_EX;
            next_imemaddr_EX_MEM <= next_imemaddr_ID_EX;
            halt_EX_MEM          <= halt_ID_EX;
`ifdef EX_MEM_TRACKER_EN
            instruction_EX_MEM   <= instruction_ID_EX;
            imemaddr_EX_MEM      <= imemaddr_ID_EX;
            opcode_EX_MEM        <= opcode_ID_EX;
            func_EX_MEM          <= func_ID_EX;
            imm16_EX_MEM         <= imm16_ID_EX;
`endif
        end
    end
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed self-checking bench for ex_mem_reg
module tb_ex_mem_reg;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        enable_EX_MEM = 1'b0;
    logic        flush_EX_MEM = 1'b0;
    logic        dREN_ID_EX = 1'b0;
    logic        dWEN_ID_EX = 1'b0;
    logic        WEN_ID_EX = 1'b0;
    logic        halt_ID_EX = 1'b0;
    logic [1:0]  mem_to_reg_ID_EX = 2'd0;
    logic [4:0]  wsel_EX = 5'd0;
    logic [31:0] alu_result_EX = 32'd0;
    logic [31:0] rdat2_ID_EX = 32'd0;
    logic [31:0] next_imemaddr_ID_EX = 32'd0;
    logic        dhit = 1'b0;
    logic        dREN_EX_MEM, dWEN_EX_MEM, WEN_EX_MEM, halt_EX_MEM, mem_stall;
    logic [31:0] dmemaddr, dmemstore, alu_result_EX_MEM, next_imemaddr_EX_MEM;
    logic [4:0]  wsel_EX_MEM;
    logic [1:0]  mem_to_reg_EX_MEM;
    int          n_chk = 0;
    int          n_fail = 0;

    ex_mem_reg dut (
        .CLK(CLK), .RST(RST),
        .enable_EX_MEM(enable_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
        .dREN_ID_EX(dREN_ID_EX), .dWEN_ID_EX(dWEN_ID_EX), .WEN_ID_EX(WEN_ID_EX),
        .halt_ID_EX(halt_ID_EX), .mem_to_reg_ID_EX(mem_to_reg_ID_EX), .wsel_EX(wsel_EX),
        .alu_result_EX(alu_result_EX), .rdat2_ID_EX(rdat2_ID_EX),
        .next_imemaddr_ID_EX(next_imemaddr_ID_EX), .dhit(dhit),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .alu_result_EX_MEM(alu_result_EX_MEM), .WEN_EX_MEM(WEN_EX_MEM),
        .wsel_EX_MEM(wsel_EX_MEM), .mem_to_reg_EX_MEM(mem_to_reg_EX_MEM),
        .next_imemaddr_EX_MEM(next_imemaddr_EX_MEM), .halt_EX_MEM(halt_EX_MEM),
        .mem_stall(mem_stall)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic fl, input logic ren, input logic wen,
                         input logic rw, input logic hlt, input logic [1:0] m2r,
                         input logic [4:0] ws, input logic [31:0] alu, input logic [31:0] st);
        enable_EX_MEM = en; flush_EX_MEM = fl; dREN_ID_EX = ren; dWEN_ID_EX = wen;
        WEN_ID_EX = rw; halt_ID_EX = hlt; mem_to_reg_ID_EX = m2r; wsel_EX = ws;
        alu_result_EX = alu; rdat2_ID_EX = st; next_imemaddr_ID_EX = alu + 32'h1000;
    endtask

    initial begin
        #12;
        chk("rst_dren", 32'(dREN_EX_MEM), 0);
        chk("rst_alu", alu_result_EX_MEM, 0);
        chk("rst_stall", 32'(mem_stall), 0);
        RST = 1'b0;
        step();
        // plain ALU op
        drive(1, 0, 0, 0, 1, 0, 2'd0, 5'd5, 32'h10, 32'h0);
        step();
        chk("alu_res", alu_result_EX_MEM, 32'h10);
        chk("alu_wsel", 32'(wsel_EX_MEM), 5);
        chk("alu_wen", 32'(WEN_EX_MEM), 1);
        chk("alu_stall", 32'(mem_stall), 0);
        chk("alu_addr", dmemaddr, 32'h10);
        chk("alu_link", next_imemaddr_EX_MEM, 32'h1010);
        // store with dhit after 3 cycles; enable held high must be ignored
        drive(1, 0, 0, 1, 0, 0, 2'd0, 5'd0, 32'h100, 32'hDEADBEEF);
        step();
        drive(1, 0, 0, 0, 1, 0, 2'd0, 5'd9, 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("st_dwen", 32'(dWEN_EX_MEM), 1);
            chk("st_stall", 32'(mem_stall), 1);
            chk("st_addr", dmemaddr, 32'h100);
            chk("st_data", dmemstore, 32'hDEADBEEF);
            step();
        end
        dhit = 1'b1;
        #1;
        chk("st_hit_stall", 32'(mem_stall), 0);
        step();
        dhit = 1'b0;
        chk("st_done_dwen", 32'(dWEN_EX_MEM), 0);
        chk("st_done_alu", alu_result_EX_MEM, 32'h100);
        chk("st_done_stall", 32'(mem_stall), 0);
        // enable out of DONE loads the next op
        step();
        chk("done_load_alu", alu_result_EX_MEM, 32'h200);
        chk("done_load_wsel", 32'(wsel_EX_MEM), 9);
        chk("done_load_dwen", 32'(dWEN_EX_MEM), 0);
        // load flushed while in flight
        drive(1, 0, 1, 0, 1, 0, 2'd1, 5'd7, 32'h300, 32'h0);
        step();
        chk("ld_dren", 32'(dREN_EX_MEM), 1);
        chk("ld_stall", 32'(mem_stall), 1);
        drive(0, 1, 0, 0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0);
        step();
        flush_EX_MEM = 1'b0;
        chk("fl_dren_held", 32'(dREN_EX_MEM), 1);
        chk("fl_wen_held", 32'(WEN_EX_MEM), 1);
        step();
        chk("fl_dren_held2", 32'(dREN_EX_MEM), 1);
        dhit = 1'b1;
        step();
        dhit = 1'b0;
        chk("fl_dren_drop", 32'(dREN_EX_MEM), 0);
        chk("fl_wen_bubble", 32'(WEN_EX_MEM), 0);
        chk("fl_m2r_bubble", 32'(mem_to_reg_EX_MEM), 0);
        chk("fl_alu_kept", alu_result_EX_MEM, 32'h300);
        chk("fl_stall", 32'(mem_stall), 0);
        // illegal simultaneous read and write: store wins
        drive(1, 0, 1, 1, 0, 0, 2'd0, 5'd0, 32'h400, 32'h55);
        step();
        chk("both_dwen", 32'(dWEN_EX_MEM), 1);
        chk("both_dren", 32'(dREN_EX_MEM), 0);
        enable_EX_MEM = 1'b0;
        dhit = 1'b1;
        step();
        dhit = 1'b0;
        // enable and flush together: bubble, no request
        drive(1, 1, 1, 0, 1, 0, 2'd1, 5'd3, 32'h500, 32'h0);
        step();
        chk("ef_dren", 32'(dREN_EX_MEM), 0);
        chk("ef_wen", 32'(WEN_EX_MEM), 0);
        chk("ef_stall", 32'(mem_stall), 0);
        chk("ef_alu_kept", alu_result_EX_MEM, 32'h400);
        // halt is sticky and turns later enables into bubbles
        drive(1, 0, 0, 0, 1, 1, 2'd0, 5'd2, 32'h600, 32'h0);
        step();
        chk("halt_set", 32'(halt_EX_MEM), 1);
        chk("halt_alu", alu_result_EX_MEM, 32'h600);
        drive(0, 1, 0, 0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("halt_after_flush", 32'(halt_EX_MEM), 1);
        drive(1, 0, 1, 0, 1, 0, 2'd1, 5'd4, 32'h700, 32'h0);
        step();
        chk("halt_sticky", 32'(halt_EX_MEM), 1);
        chk("halt_bubble_dren", 32'(dREN_EX_MEM), 0);
        chk("halt_bubble_wen", 32'(WEN_EX_MEM), 0);
        chk("halt_bubble_alu", alu_result_EX_MEM, 32'h600);
        // asynchronous reset in the middle of a request
        RST = 1'b1;
        #1;
        chk("rst_halt_clr", 32'(halt_EX_MEM), 0);
        RST = 1'b0;
        drive(1, 0, 1, 0, 1, 0, 2'd1, 5'd6, 32'h800, 32'h0);
        step();
        enable_EX_MEM = 1'b0;
        chk("rq_dren", 32'(dREN_EX_MEM), 1);
        chk("rq_stall", 32'(mem_stall), 1);
        #1;
        RST = 1'b1;
        #1;
        chk("arst_dren", 32'(dREN_EX_MEM), 0);
        chk("arst_stall", 32'(mem_stall), 0);
        chk("arst_alu", alu_result_EX_MEM, 0);
        chk("arst_wsel", 32'(wsel_EX_MEM), 0);
        chk("arst_link", next_imemaddr_EX_MEM, 0);
        RST = 1'b0;
        // after reset the register is IDLE and accepts a fresh op
        drive(1, 0, 0, 0, 1, 0, 2'd2, 5'd31, 32'h900, 32'h0);
        step();
        chk("post_rst_alu", alu_result_EX_MEM, 32'h900);
        chk("post_rst_m2r", 32'(mem_to_reg_EX_MEM), 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
